// File: rtl/exec_pkg.sv
// Shared definitions for the execute-to-writeback stage: flag bit positions,
// the default load opcode and the default-width writeback entry.
package exec_pkg;

  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_SIGN  = 1;
  localparam int FLAG_CARRY = 0;

  localparam logic [4:0] LOAD_OPC_DEF = 5'b11001;

  localparam int ENTRY_DATA_W = 32;
  localparam int ENTRY_DEST_W = 4;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] data;
    logic [ENTRY_DEST_W-1:0] dest;
  } exec_entry_t;

  function automatic logic [2:0] pack_flags(input logic zero, input logic sign, input logic carry);
    logic [2:0] f;
    f             = 3'b000;
    f[FLAG_ZERO]  = zero;
    f[FLAG_SIGN]  = sign;
    f[FLAG_CARRY] = carry;
    return f;
  endfunction

endpackage

// File: rtl/exec_flag_unit.sv
// Combinational result select and {zero, sign, carry} flag computation for
// the operation currently offered by execute.
module exec_flag_unit
  import exec_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] LOAD_OPC = OPC_W'(LOAD_OPC_DEF)
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] idata,
  input  logic              carry,
  output logic [DATA_W-1:0] sel,
  output logic [2:0]        flags,
  output logic              is_load
);

  // Zero is taken from the selected value, sign from a signed A<B compare.
  always_comb begin
    is_load = (opcode == LOAD_OPC);
    if (is_load) begin
      sel = idata;
    end else begin
      sel = result;
    end
    flags = pack_flags(sel == {DATA_W{1'b0}}, $signed(a) < $signed(b), carry);
  end

endmodule

// File: rtl/exec_wb_stage.sv
// Registered execute-to-writeback stage with valid/ready handshake, flag
// register and retired counter. Define EXEC_WB_SKID_EN for a two-entry skid buffer.
module exec_wb_stage
  import exec_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               DEST_W   = 4,
  parameter int               OPC_W    = 5,
  parameter logic [OPC_W-1:0] LOAD_OPC = OPC_W'(LOAD_OPC_DEF),
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [OPC_W-1:0]  opcode_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] idata_in,
  input  logic              carry_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [2:0]        flags_out,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } entry_t;

  logic [DATA_W-1:0] sel_s;
  logic [2:0]        new_flags_s;
  logic              is_load_s;
  logic              in_xfer_s;
  logic              out_xfer_s;
  entry_t            new_entry_s;
  entry_t            main_s;
  entry_t            main_r;
  logic              main_valid_s;
  logic              main_valid_r;
  logic [2:0]        flags_r;
  logic [CNT_W-1:0]  cnt_r;

  exec_flag_unit #(
    .DATA_W   (DATA_W),
    .OPC_W    (OPC_W),
    .LOAD_OPC (LOAD_OPC)
  ) u_flag_unit (
    .opcode  (opcode_in),
    .a       (a_in),
    .b       (b_in),
    .result  (result_in),
    .idata   (idata_in),
    .carry   (carry_in),
    .sel     (sel_s),
    .flags   (new_flags_s),
    .is_load (is_load_s)
  );

  assign new_entry_s = '{data: sel_s, dest: dest_in};
  assign in_xfer_s   = in_valid & in_ready & ~flush;
  assign out_xfer_s  = main_valid_r & out_ready;

`ifdef EXEC_WB_SKID_EN
  entry_t skid_s;
  entry_t skid_r;
  logic   skid_valid_s;
  logic   skid_valid_r;
  logic   in_ready_r;

  // Main/skid next state; a stalled main diverts the accepted input to skid.
  always_comb begin
    main_s       = main_r;
    main_valid_s = main_valid_r;
    skid_s       = skid_r;
    skid_valid_s = skid_valid_r;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (~main_valid_r | out_xfer_s) begin
      if (skid_valid_r) begin
        main_s       = skid_r;
        main_valid_s = 1'b1;
        skid_valid_s = 1'b0;
      end else if (in_xfer_s) begin
        main_s       = new_entry_s;
        main_valid_s = 1'b1;
      end else begin
        main_valid_s = 1'b0;
      end
    end else begin
      if (in_xfer_s) begin
        skid_s       = new_entry_s;
        skid_valid_s = 1'b1;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Skid entry and registered ready; ready stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r       <= '0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      skid_r       <= skid_s;
      skid_valid_r <= skid_valid_s;
      in_ready_r   <= ~skid_valid_s;
    end
  end

  assign in_ready = in_ready_r;
`else
  logic rdy_en_r;

  // Single entry: a simultaneous in/out transfer replaces it without a bubble.
  always_comb begin
    main_s       = main_r;
    main_valid_s = main_valid_r;
    if (flush) begin
      main_valid_s = 1'b0;
    end else if (in_xfer_s) begin
      main_s       = new_entry_s;
      main_valid_s = 1'b1;
    end else if (out_xfer_s) begin
      main_valid_s = 1'b0;
    end else begin
      main_valid_s = main_valid_r;
    end
  end

  // Holds ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_r <= 1'b0;
    end else begin
      rdy_en_r <= 1'b1;
    end
  end

  assign in_ready = rdy_en_r & (~main_valid_r | out_ready);
`endif

  // Main entry register feeding the writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r       <= '0;
      main_valid_r <= 1'b0;
    end else begin
      main_r       <= main_s;
      main_valid_r <= main_valid_s;
    end
  end

  // Architectural flags follow accepted non-load operations only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 3'b000;
    end else if (in_xfer_s & ~is_load_s) begin
      flags_r <= new_flags_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  // Retired counter wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign out_valid   = main_valid_r;
  assign data_out    = main_r.data;
  assign dest_out    = main_r.dest;
  assign flags_out   = flags_r;
  assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_exec_wb_stage.sv
// Directed self-checking bench for exec_wb_stage (CNT_W=4 so the counter wraps).
module tb_exec_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dest_in;
  logic [4:0]  opcode_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] result_in;
  logic [31:0] idata_in;
  logic        carry_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  dest_out;
  logic [2:0]  flags_out;
  logic [3:0]  retired_cnt;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_cnt;
  int acc;
  int outs;
  int order_err;

  exec_wb_stage #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dest_in(dest_in), .opcode_in(opcode_in), .a_in(a_in), .b_in(b_in),
    .result_in(result_in), .idata_in(idata_in), .carry_in(carry_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .dest_out(dest_out), .flags_out(flags_out),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] opc, input logic [3:0] dst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic [31:0] imm,
                       input logic cy);
    in_valid  = 1'b1;
    opcode_in = opc;
    dest_in   = dst;
    a_in      = a;
    b_in      = b;
    result_in = res;
    idata_in  = imm;
    carry_in  = cy;
  endtask

  task automatic send(input logic [4:0] opc, input logic [3:0] dst, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res, input logic [31:0] imm,
                      input logic cy);
    drive(opc, dst, a, b, res, imm, cy);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; dest_in = 4'd0; opcode_in = 5'd0;
    a_in = 32'd0; b_in = 32'd0; result_in = 32'd0; idata_in = 32'd0;
    carry_in = 1'b0; flush = 1'b0; out_ready = 1'b1; exp_cnt = 4'd0;

    // Reset state
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_dest", {28'd0, dest_out}, 32'd0);
    check("rst_flags", {29'd0, flags_out}, 32'd0);
    check("rst_cnt", {28'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Load vs ALU, streaming with out_ready=1
    send(5'b11001, 4'd3, 32'd0, 32'd0, 32'h0000FFFF, 32'h00001234, 1'b1);
    check("load_valid", {31'd0, out_valid}, 32'd1);
    check("load_data", data_out, 32'h00001234);
    check("load_dest", {28'd0, dest_out}, 32'd3);
    check("load_flags", {29'd0, flags_out}, 32'd0);
    send(5'b00001, 4'd5, 32'd5, 32'd7, 32'd0, 32'h00001234, 1'b0);
    check("alu_data", data_out, 32'd0);
    check("alu_dest", {28'd0, dest_out}, 32'd5);
    check("alu_flags", {29'd0, flags_out}, 32'b110);
    send(5'b00010, 4'd6, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd0, 1'b1);
    check("neg_data", data_out, 32'h80000000);
    check("neg_flags", {29'd0, flags_out}, 32'b011);
    send(5'b00010, 4'd7, 32'd1, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0);
    check("pos_flags", {29'd0, flags_out}, 32'b000);
    send(5'b11001, 4'd8, 32'd0, 32'd9, 32'd5, 32'd0, 1'b1);
    check("load0_data", data_out, 32'd0);
    check("load0_flags", {29'd0, flags_out}, 32'b000);
    tick();
    exp_cnt = exp_cnt + 4'd5;
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("cnt_after_alu", {28'd0, retired_cnt}, {28'd0, exp_cnt});

    // Back-pressure: A held, B offered for three stalled cycles
    out_ready = 1'b0;
    send(5'b00010, 4'd1, 32'd0, 32'd0, 32'h0000AAAA, 32'd0, 1'b0);
    drive(5'b00010, 4'd2, 32'd1, 32'd2, 32'h0000BBBB, 32'd0, 1'b1);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_valid && in_ready) acc++;
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", data_out, 32'h0000AAAA);
      check("bp_dest", {28'd0, dest_out}, 32'd1);
    end
`ifdef EXEC_WB_SKID_EN
    check("bp_accepts", acc, 32'd1);
    check("bp_flags", {29'd0, flags_out}, 32'b011);
    in_valid = 1'b0;
`else
    check("bp_accepts", acc, 32'd0);
    check("bp_flags", {29'd0, flags_out}, 32'b000);
`endif
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_b_data", data_out, 32'h0000BBBB);
    check("bp_b_dest", {28'd0, dest_out}, 32'd2);
    tick();
    exp_cnt = exp_cnt + 4'd2;
    check("bp_drain", {31'd0, out_valid}, 32'd0);
    check("bp_flags_final", {29'd0, flags_out}, 32'b011);
    check("bp_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});

    // Flush: C held, D offered with flush
    out_ready = 1'b0;
    send(5'b00010, 4'd4, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    check("fl_held", {31'd0, out_valid}, 32'd1);
    check("fl_c_flags", {29'd0, flags_out}, 32'b100);
    drive(5'b00010, 4'd9, 32'd3, 32'd9, 32'd5, 32'd0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_flags", {29'd0, flags_out}, 32'b100);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});
    // Flush while empty: offered op dropped, no flag update
    drive(5'b00010, 4'd9, 32'd3, 32'd9, 32'd5, 32'd0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl2_valid", {31'd0, out_valid}, 32'd0);
    check("fl2_flags", {29'd0, flags_out}, 32'b100);

    // Streaming: 100 ops over 101 edges
    out_ready = 1'b1;
    acc = 0; outs = 0; order_err = 0;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) drive(5'b00010, 4'd1, 32'd0, 32'd0, i, 32'd0, 1'b0);
      else in_valid = 1'b0;
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        if (data_out !== outs) order_err++;
        outs++;
      end
      tick();
    end
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 4'(100);
    check("st_accepted", acc, 32'd100);
    check("st_outputs", outs, 32'd100);
    check("st_order_errs", order_err, 32'd0);
    check("st_empty", {31'd0, out_valid}, 32'd0);
    check("st_cnt", {28'd0, retired_cnt}, {28'd0, exp_cnt});

    // Reset mid-operation
    out_ready = 1'b0;
    send(5'b00010, 4'd9, 32'd0, 32'd0, 32'h0000DEAD, 32'd0, 1'b1);
    check("mr_held", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_data", data_out, 32'd0);
    check("mr_flags", {29'd0, flags_out}, 32'd0);
    check("mr_cnt", {28'd0, retired_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);

    // Counter wrap: 17 output transfers from zero
    for (int i = 0; i < 17; i++) begin
      send(5'b00011, 4'd2, 32'd0, 32'd0, i + 1, 32'd0, 1'b0);
    end
    tick();
    check("wrap_cnt", {28'd0, retired_cnt}, 32'd1);
    check("wrap_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Registered execute-to-writeback pipeline stage; successor of the combinational execute transmitter.
- Selects the load immediate or the ALU result, computes {zero, sign, carry} flags, and holds them in an architectural flag register.
- Decouples execute from writeback with a valid/ready handshake.
- Parametrised in data, destination and opcode widths.

Parameters:
- DATA_W, 32, width of operands, result and immediate.
- DEST_W, 4, destination register index width.
- OPC_W, 5, opcode width.
- LOAD_OPC, 5'b11001, opcode that selects idata_in as the result.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an operation.
- in_ready  out  1  stage accepts the operation this cycle.
- dest_in  in  DEST_W  destination register index.
- opcode_in  in  OPC_W  operation code.
- a_in  in  DATA_W  operand A.
- b_in  in  DATA_W  operand B.
- result_in  in  DATA_W  ALU result.
- idata_in  in  DATA_W  load/immediate data.
- carry_in  in  1  ALU carry out.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes the entry.
- data_out  out  DATA_W  selected result.
- dest_out  out  DEST_W  destination index.
- flags_out  out  3  architectural flags {zero, sign, carry}.
- retired_cnt  out  CNT_W  count of entries consumed by writeback.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, data_out=0, dest_out=0, flags_out=3'b000, retired_cnt=0.
  - in_ready=1 one cycle after rst_n deasserts, and stays 1 while out_valid=0.
- Transfer rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
  - Payload and out_valid hold stable while out_valid & ~out_ready.
- Result select:
  - sel = idata_in when opcode_in==LOAD_OPC, else result_in.
  - Captured into the entry on input transfer.
  - Latency: 1 cycle from input transfer to out_valid.
- Flags, computed from inputs at transfer time:
  - zero = (sel == 0). This differs from the old OR-of-operands rule.
  - sign = signed compare $signed(a_in) < $signed(b_in).
  - carry = carry_in.
  - flags_out register updates on input transfer of any non-load opcode.
  - Load transfers leave flags_out unchanged.
  - Flags are not rolled back by flush.
- Base configuration (single entry):
  - in_ready = ~out_valid | out_ready (combinational through out_ready).
  - Simultaneous input and output transfer: the entry is replaced with no bubble.
- retired_cnt:
  - +1 on each output transfer.
  - Wraps from 2^CNT_W-1 to 0 without saturation.
  - Not affected by flush.
- flush:
  - Next edge: out_valid=0 and any skid entry is cleared.
  - An input offered in the same cycle is dropped; its flag update is also suppressed.
  - in_ready=1 the following cycle.
- Reset mid-operation: held entries are discarded immediately; no partial output transfer.
- All arithmetic is unsigned modulo 2^DATA_W except the sign compare.

Optional Feature:
- Macro: EXEC_WB_SKID_EN.
- Defined:
  - Two-entry skid buffer (main + skid); in_ready is a registered ~skid_valid, with no combinational path from out_ready.
  - If the main entry is stalled and an input transfers, the input goes to skid.
  - On the next output transfer, skid moves to main.
  - Order is strictly FIFO.
  - Full-throughput streaming with out_ready=1 is still 1 op/cycle.
- Undefined: single-entry behaviour as above.
- Flag-update timing is identical in both builds: flags update on input transfer, not output.

Decomposition:
- Package exec_pkg:
  - FLAG_ZERO=2, FLAG_SIGN=1, FLAG_CARRY=0 bit indices.
  - Default LOAD_OPC constant.
  - Typedef exec_entry_t {data, dest}.
- One sub-module, exec_flag_unit: combinational sel/flag computation, instantiated once.
- Top level owns the handshake, entries, flag register and counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream → outputs zero immediately; after release in_ready=1, out_valid=0.
- Load vs ALU: opcode=5'b11001, idata=0x1234, result=0xFFFF → data_out=0x1234, flags unchanged. Then opcode=5'b00001, result=0, a=5, b=7 → data_out=0, flags=3'b110 (carry_in=0).
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → payload stable. Base build accepts 0 extra; skid build accepts exactly 1 extra; in-order delivery after release.
- Streaming: out_ready=1, 100 consecutive ops → 100 outputs in 101 cycles, retired_cnt=100.
- Flush: 1 held + 1 offered op with flush=1 → next cycle out_valid=0, flags reflect only pre-flush transfers.
- Counter wrap: CNT_W=4, 17 output transfers → retired_cnt=1.
